// File: rtl/iq_unpack_pkg.sv
// Shared definitions for the I/Q unpacker: state encoding, default quantizer
// shift and the sample quantizer used by the front end of the FM chain.
package iq_unpack_pkg;

  // Default number of fractional bits applied to each sample.
  localparam int unsigned QUANT_BITS_DEFAULT = 10;

  // Widest result the quantizer produces; callers cast down to their width.
  localparam int unsigned QUANT_WIDE_W = 64;

  typedef enum logic {
    S_READ  = 1'b0,
    S_WRITE = 1'b1
  } iq_unpack_state_t;

  // Sign-extend a 16-bit sample and shift it into fixed point.
  // Bits above the caller's width are simply dropped (no saturation).
  function automatic logic [QUANT_WIDE_W-1:0] quantize_i(
    input logic [15:0] sample,
    input int unsigned qbits
  );
    logic [QUANT_WIDE_W-1:0] ext;
    ext = {{(QUANT_WIDE_W-16){sample[15]}}, sample};
    return ext << qbits;
  endfunction

endpackage

// File: rtl/iq_unpack.sv
// iq_unpack: pops packed 32-bit I/Q words from a first-word-fall-through FIFO,
// quantizes each half to DATA_WIDTH fixed point and pushes the pair into the
// real/imaginary FIFOs feeding the complex channel FIR.
//
// Optional feature: define IQ_COUNT_EN to build the 32-bit paired-write
// counter on sample_count; otherwise sample_count is tied to zero.
//
// state   | meaning
// S_READ  | waiting for an input word; pops it and captures I/Q
// S_WRITE | holding a captured pair until both output FIFOs have room
module iq_unpack
  import iq_unpack_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned QUANT_BITS = QUANT_BITS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           in_dout,
  input  logic                  in_empty,
  output logic                  in_rd_en,
  output logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] q_din,
  output logic                  i_wr_en,
  output logic                  q_wr_en,
  input  logic                  i_full,
  input  logic                  q_full,
  output logic [31:0]           sample_count
);

  iq_unpack_state_t r_state;
  iq_unpack_state_t w_state_nxt;

  logic [DATA_WIDTH-1:0] r_i_sample;
  logic [DATA_WIDTH-1:0] r_q_sample;

  logic [DATA_WIDTH-1:0] w_i_quant;
  logic [DATA_WIDTH-1:0] w_q_quant;
  logic                  w_pop;
  logic                  w_push;

  // Word split: I in the low half, Q in the high half, both signed.
  assign w_i_quant = DATA_WIDTH'(quantize_i(in_dout[15:0],  QUANT_BITS));
  assign w_q_quant = DATA_WIDTH'(quantize_i(in_dout[31:16], QUANT_BITS));

  // State register; reset abandons any pending pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_READ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode. Strobes are gated by rst so every
  // output is quiet for the whole reset window, not just after the edge.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_push      = 1'b0;
    unique case (r_state)
      S_READ: begin
        if (!in_empty && !rst) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!i_full && !q_full && !rst) begin
          w_push      = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      default: w_state_nxt = S_READ;
    endcase
  end

  // Capture the quantized pair in the pop cycle; held until the next pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i_sample <= '0;
      r_q_sample <= '0;
    end else if (w_pop) begin
      r_i_sample <= w_i_quant;
      r_q_sample <= w_q_quant;
    end
  end

  assign in_rd_en = w_pop;
  assign i_wr_en  = w_push;
  assign q_wr_en  = w_push;
  assign i_din    = r_i_sample;
  assign q_din    = r_q_sample;

`ifdef IQ_COUNT_EN
  logic [31:0] r_sample_count;

  // Count paired writes; wraps naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sample_count <= '0;
    end else if (w_push) begin
      r_sample_count <= r_sample_count + 32'd1;
    end
  end

  assign sample_count = r_sample_count;
`else
  assign sample_count = '0;
`endif

endmodule

// File: tb/tb_iq_unpack.sv
// Directed bench for iq_unpack: reset state, quantization of several words,
// full-flag stalls, empty input, reset while a pair is pending, and a long
// stream checking the pair counter.
module tb_iq_unpack;

  localparam int unsigned DW = 32;
  localparam int unsigned QB = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   in_dout;
  logic          in_empty;
  logic          in_rd_en;
  logic [DW-1:0] i_din;
  logic [DW-1:0] q_din;
  logic          i_wr_en;
  logic          q_wr_en;
  logic          i_full;
  logic          q_full;
  logic [31:0]   sample_count;

  int n_checks = 0;
  int n_errors = 0;

  iq_unpack #(.DATA_WIDTH(DW), .QUANT_BITS(QB)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_dout      (in_dout),
    .in_empty     (in_empty),
    .in_rd_en     (in_rd_en),
    .i_din        (i_din),
    .q_din        (q_din),
    .i_wr_en      (i_wr_en),
    .q_wr_en      (q_wr_en),
    .i_full       (i_full),
    .q_full       (q_full),
    .sample_count (sample_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Move to 1 ns after the next rising edge; inputs are driven here and
  // outputs sampled 1 ns later, well clear of both edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Reference quantizer for the streamed section only.
  function automatic logic [31:0] exp_q(input logic [15:0] s);
    logic [31:0] ext;
    ext = {{16{s[15]}}, s};
    return ext << QB;
  endfunction

  logic [31:0] exp_count;
  logic [31:0] held_i;
  logic [31:0] held_q;
  int          pops;
  int          writes;
  int          split_writes;

  initial begin
    rst      = 1'b1;
    in_dout  = 32'h0;
    in_empty = 1'b0;
    i_full   = 1'b0;
    q_full   = 1'b0;

    // Reset state: input offered but nothing may move while rst is high.
    tick();
    tick();
    settle();
    check("rst_rd_en", {31'b0, in_rd_en}, 32'd0);
    check("rst_wr_en", {30'b0, i_wr_en, q_wr_en}, 32'd0);
    check("rst_i_din", i_din, 32'd0);
    check("rst_q_din", q_din, 32'd0);
    check("rst_count", sample_count, 32'd0);

    in_empty = 1'b1;
    tick();
    rst = 1'b0;

    // Word 0x00020001: I=1 -> 1024, Q=2 -> 2048; pop then write next cycle.
    tick();
    in_dout  = 32'h0002_0001;
    in_empty = 1'b0;
    settle();
    check("w1_rd_en", {31'b0, in_rd_en}, 32'd1);
    check("w1_pop_wr", {30'b0, i_wr_en, q_wr_en}, 32'd0);
    tick();
    in_empty = 1'b1;
    settle();
    check("w1_rd_idle", {31'b0, in_rd_en}, 32'd0);
    check("w1_wr_en", {30'b0, i_wr_en, q_wr_en}, 32'b11);
    check("w1_i_din", i_din, 32'd1024);
    check("w1_q_din", q_din, 32'd2048);
    tick();
    settle();
    check("w1_wr_done", {30'b0, i_wr_en, q_wr_en}, 32'd0);

    // Word 0xFFFF8000: I=-32768 -> 0xFE000000, Q=-1 -> 0xFFFFFC00.
    in_dout  = 32'hFFFF_8000;
    in_empty = 1'b0;
    settle();
    check("w2_rd_en", {31'b0, in_rd_en}, 32'd1);
    tick();
    in_empty = 1'b1;
    settle();
    check("w2_wr_en", {30'b0, i_wr_en, q_wr_en}, 32'b11);
    check("w2_i_din", i_din, 32'hFE00_0000);
    check("w2_q_din", q_din, 32'hFFFF_FC00);
    tick();

    // Stall: q_full high for 5 cycles after popping 0x0003FFFD
    // (I=-3 -> 0xFFFFF400, Q=3 -> 0x00000C00). Input stays non-empty with a
    // different word to prove nothing is popped or recaptured while pending.
    in_dout  = 32'h0003_FFFD;
    in_empty = 1'b0;
    q_full   = 1'b1;
    settle();
    check("st_rd_en", {31'b0, in_rd_en}, 32'd1);
    for (int c = 0; c < 5; c++) begin
      tick();
      in_dout = 32'h0004_0005;
      settle();
      check("st_wr_hold", {30'b0, i_wr_en, q_wr_en}, 32'd0);
      check("st_rd_hold", {31'b0, in_rd_en}, 32'd0);
      check("st_i_din", i_din, 32'hFFFF_F400);
      check("st_q_din", q_din, 32'h0000_0C00);
    end
    // i_full alone must also block the pair.
    tick();
    q_full = 1'b0;
    i_full = 1'b1;
    settle();
    check("st_ifull_wr", {30'b0, i_wr_en, q_wr_en}, 32'd0);
    tick();
    i_full = 1'b0;
    settle();
    check("st_release_wr", {30'b0, i_wr_en, q_wr_en}, 32'b11);
    check("st_release_i", i_din, 32'hFFFF_F400);
    // Next word 0x00040005 pops right after the write: I=5 -> 5120, Q=4 -> 4096.
    tick();
    settle();
    check("st_next_rd", {31'b0, in_rd_en}, 32'd1);
    tick();
    in_empty = 1'b1;
    settle();
    check("st_next_wr", {30'b0, i_wr_en, q_wr_en}, 32'b11);
    check("st_next_i", i_din, 32'd5120);
    check("st_next_q", q_din, 32'd4096);
    tick();

    // Empty input for 10 cycles: no strobes, data registers unchanged.
    for (int c = 0; c < 10; c++) begin
      settle();
      check("em_rd_en", {31'b0, in_rd_en}, 32'd0);
      check("em_wr_en", {30'b0, i_wr_en, q_wr_en}, 32'd0);
      tick();
    end
    check("em_i_din", i_din, 32'd5120);

`ifdef IQ_COUNT_EN
    exp_count = 32'd4;
`else
    exp_count = 32'd0;
`endif
    check("cnt_before_rst", sample_count, exp_count);

    // Reset while a pair is pending behind i_full: everything drops to 0.
    in_dout  = 32'h0005_0007;
    in_empty = 1'b0;
    i_full   = 1'b1;
    settle();
    check("rw_rd_en", {31'b0, in_rd_en}, 32'd1);
    tick();
    rst = 1'b1;
    settle();
    check("rw_i_din", i_din, 32'd0);
    check("rw_q_din", q_din, 32'd0);
    check("rw_rd_en_rst", {31'b0, in_rd_en}, 32'd0);
    check("rw_wr_en_rst", {30'b0, i_wr_en, q_wr_en}, 32'd0);
    check("rw_count_rst", sample_count, 32'd0);
    tick();
    rst     = 1'b0;
    i_full  = 1'b0;
    in_dout = 32'h0001_0002;
    settle();
    check("rw_after_rd", {31'b0, in_rd_en}, 32'd1);
    tick();
    in_empty = 1'b1;
    settle();
    check("rw_after_wr", {30'b0, i_wr_en, q_wr_en}, 32'b11);
    check("rw_after_i", i_din, 32'd2048);
    check("rw_after_q", q_din, 32'd1024);
    tick();

    // Stream 1000 words back to back with outputs never full.
    rst = 1'b1;
    tick();
    rst          = 1'b0;
    pops         = 0;
    writes       = 0;
    split_writes = 0;
    in_empty     = 1'b0;
    held_i       = 32'd0;
    held_q       = 32'd0;
    for (int c = 0; c < 2000; c++) begin
      in_dout = {16'(pops) ^ 16'h8000, 16'(pops)};
      settle();
      if (in_rd_en) begin
        held_i = exp_q(in_dout[15:0]);
        held_q = exp_q(in_dout[31:16]);
        pops++;
      end
      if (i_wr_en != q_wr_en) split_writes++;
      if (i_wr_en && q_wr_en) writes++;
      tick();
    end
    in_empty = 1'b1;
    settle();
    check("str_pops", 32'(pops), 32'd1000);
    check("str_writes", 32'(writes), 32'd1000);
    check("str_split", 32'(split_writes), 32'd0);
    check("str_last_i", i_din, held_i);
    check("str_last_q", q_din, held_q);
`ifdef IQ_COUNT_EN
    exp_count = 32'd1000;
`else
    exp_count = 32'd0;
`endif
    check("str_count", sample_count, exp_count);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
